// File: rtl/fetch_pc_redirect.sv
// fetch_pc_redirect: fetch PC generator with branch-mispredict recovery,
// wrong-path hold window and saturating branch/mispredict counters.
module fetch_pc_redirect #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
    parameter int                    FLUSH_DEPTH = 2,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_if_pred_taken,
    input  logic [DATA_WIDTH-1:0] i_if_pred_target,
    input  logic                  i_ex_mem_is_branch,
    input  logic                  i_ex_mem_taken,
    input  logic [DATA_WIDTH-1:0] i_ex_mem_target,
    input  logic [DATA_WIDTH-1:0] i_ex_mem_pc,
    input  logic                  i_ex_mem_pred_taken,
    input  logic [DATA_WIDTH-1:0] i_ex_mem_pred_tgt,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_flush,
    output logic                  o_redirect,
    output logic                  o_recovering,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_mispred_cnt
);
    // A zero depth would leave no wrong-path window at all, so clamp to one cycle.
    localparam int                    FD        = (FLUSH_DEPTH < 1) ? 1 : FLUSH_DEPTH;
    localparam int                    HW        = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [HW-1:0]         HOLD_INIT = HW'(FD - 1);
    localparam logic [DATA_WIDTH-1:0] STEP      = DATA_WIDTH'(4);

    typedef enum logic {RUN, HOLD} state_t;

    state_t                  state, state_nx;
    logic [HW-1:0]           hold_cnt, hold_nx;
    logic                    rv, mp;
    logic [DATA_WIDTH-1:0]   rec_pc, pc_nx;

    assign rv = i_ex_mem_is_branch && (state == RUN);
    assign mp = rv && ((i_ex_mem_taken != i_ex_mem_pred_taken) ||
                       (i_ex_mem_taken && i_ex_mem_pred_taken && (i_ex_mem_target != i_ex_mem_pred_tgt)));
    assign rec_pc = i_ex_mem_taken ? i_ex_mem_target : i_ex_mem_pc + STEP;
    assign pc_nx  = mp ? rec_pc : i_stall ? o_pc : i_if_pred_taken ? i_if_pred_target : o_pc + STEP;
    assign o_recovering = (state == HOLD);

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        if (state == RUN) begin
            if (mp) begin
                state_nx = HOLD;
                hold_nx  = HOLD_INIT;
            end
        end else if (hold_cnt == '0) begin
            state_nx = RUN;
        end else begin
            hold_nx = hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pc       <= RESET_PC;
            o_flush    <= 1'b0;
            o_redirect <= 1'b0;
        end else begin
            o_pc       <= pc_nx;
            o_flush    <= mp;
            o_redirect <= mp;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (rv && !(&o_branch_cnt))
                o_branch_cnt <= o_branch_cnt + 1'b1;
            if (mp && !(&o_mispred_cnt))
                o_mispred_cnt <= o_mispred_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_pc_redirect.sv
// tb_fetch_pc_redirect: directed + random checks of fetch_pc_redirect against a
// cycle-level reference model; a narrow-counter instance exercises saturation.
module tb_fetch_pc_redirect;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          FD     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, if_ptk, br, tk, ptk;
    logic [31:0] if_tgt, tgt, bpc, ptgt;
    logic [31:0] pc, pc_s;
    logic        flush, redir, recov, flush_s, redir_s, recov_s;
    logic [15:0] bc, mc;
    logic [3:0]  bc_s, mc_s;

    logic [31:0] m_pc;
    logic        m_flush;
    int          m_ign, m_bc, m_mc;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    fetch_pc_redirect u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_if_pred_taken(if_ptk), .i_if_pred_target(if_tgt),
        .i_ex_mem_is_branch(br), .i_ex_mem_taken(tk), .i_ex_mem_target(tgt),
        .i_ex_mem_pc(bpc), .i_ex_mem_pred_taken(ptk), .i_ex_mem_pred_tgt(ptgt),
        .o_pc(pc), .o_flush(flush), .o_redirect(redir), .o_recovering(recov),
        .o_branch_cnt(bc), .o_mispred_cnt(mc)
    );

    fetch_pc_redirect #(.CNT_WIDTH(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_if_pred_taken(if_ptk), .i_if_pred_target(if_tgt),
        .i_ex_mem_is_branch(br), .i_ex_mem_taken(tk), .i_ex_mem_target(tgt),
        .i_ex_mem_pc(bpc), .i_ex_mem_pred_taken(ptk), .i_ex_mem_pred_tgt(ptgt),
        .o_pc(pc_s), .o_flush(flush_s), .o_redirect(redir_s), .o_recovering(recov_s),
        .o_branch_cnt(bc_s), .o_mispred_cnt(mc_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic check_all();
        check("pc", pc, m_pc);
        check("flush", {31'b0, flush}, {31'b0, m_flush});
        check("redirect", {31'b0, redir}, {31'b0, m_flush});
        check("recovering", {31'b0, recov}, {31'b0, m_ign > 0});
        check("branch_cnt", {16'b0, bc}, sat(m_bc, 16'hFFFF));
        check("mispred_cnt", {16'b0, mc}, sat(m_mc, 16'hFFFF));
        check("sat_branch_cnt", {28'b0, bc_s}, sat(m_bc, 15));
        check("sat_mispred_cnt", {28'b0, mc_s}, sat(m_mc, 15));
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_flush = 0; m_ign = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic idle();
        stall = 0; if_ptk = 0; if_tgt = 0; br = 0; tk = 0; ptk = 0;
        tgt = 0; bpc = 0; ptgt = 0;
    endtask

    // One clock: predict from the inputs being applied, then compare after the edge.
    task automatic cycle();
        bit v, m;
        logic [31:0] npc;
        v = br && (m_ign == 0);
        m = v && ((tk != ptk) || (tk && tgt != ptgt));
        if (m)           npc = tk ? tgt : bpc + 32'd4;
        else if (stall)  npc = m_pc;
        else if (if_ptk) npc = if_tgt;
        else             npc = m_pc + 32'd4;
        @(posedge clk);
        #1;
        m_pc = npc;
        m_flush = m;
        m_ign = m ? FD : (m_ign > 0 ? m_ign - 1 : 0);
        m_bc += int'(v);
        m_mc += int'(m);
        check_all();
    endtask

    task automatic mispredict(input logic [31:0] at, input logic [31:0] to);
        br = 1; bpc = at; tk = 1; tgt = to; ptk = 0; ptgt = 0;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1;

        // sequential fetch from reset
        check("t1_pc0", pc, 32'h0040_0000);
        cycle(); check("t1_pc1", pc, 32'h0040_0004);
        cycle(); check("t1_pc2", pc, 32'h0040_0008);

        // predicted-taken fetch
        if_ptk = 1; if_tgt = 32'h0040_0100;
        cycle(); check("t2_pc", pc, 32'h0040_0100); check("t2_noflush", {31'b0, flush}, 32'd0);
        idle();

        // direction mispredict, then recovery window
        mispredict(32'h0040_0010, 32'h0040_0200);
        cycle(); check("t3_pc", pc, 32'h0040_0200); check("t3_flush", {31'b0, flush}, 32'd1);
        check("t3_mc", {16'b0, mc}, 32'd1); check("t3_bc", {16'b0, bc}, 32'd1);
        // wrong-path mismatching branch inside the hold window is ignored
        mispredict(32'h0040_0300, 32'h0040_0400);
        cycle(); check("t5_noflush", {31'b0, flush}, 32'd0); check("t5_mc", {16'b0, mc}, 32'd1);
        cycle(); check("t5_noredir", {31'b0, redir}, 32'd0); check("t5_bc", {16'b0, bc}, 32'd1);
        idle();
        cycle(); check("t3_recov_off", {31'b0, recov}, 32'd0);

        // predicted taken, resolved not taken, with stall in the same cycle
        br = 1; bpc = 32'h0040_0020; ptk = 1; ptgt = 32'h0040_0080; tk = 0; stall = 1;
        cycle(); check("t4_pc", pc, 32'h0040_0024); check("t4_flush", {31'b0, flush}, 32'd1);
        idle();
        repeat (3) cycle();

        // stall holds PC; taken with wrong target is a mispredict
        stall = 1; cycle(); cycle(); stall = 0;
        br = 1; bpc = 32'h1000; tk = 1; ptk = 1; tgt = 32'h2000; ptgt = 32'h2004;
        cycle(); check("tgt_mismatch_pc", pc, 32'h2000);
        idle(); repeat (2) cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            stall  = ($urandom_range(3) == 0);
            if_ptk = ($urandom_range(3) == 0);
            if_tgt = $urandom & 32'hFFFF_FFFC;
            br     = ($urandom_range(2) == 0);
            tk     = $urandom_range(1);
            ptk    = $urandom_range(1);
            tgt    = $urandom & 32'hFFFF_FFFC;
            ptgt   = $urandom_range(1) ? tgt : ($urandom & 32'hFFFF_FFFC);
            bpc    = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        idle();

        // reset in the middle of a hold window
        mispredict(32'h0040_0040, 32'h0040_0800);
        cycle();
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst_n = 1;
        cycle();

        // PC wrap, sequential and via not-taken recovery
        if_ptk = 1; if_tgt = 32'hFFFF_FFF8;
        cycle(); idle();
        cycle(); check("t6_pc_fc", pc, 32'hFFFF_FFFC);
        cycle(); check("t6_pc_wrap", pc, 32'h0000_0000);
        br = 1; bpc = 32'hFFFF_FFFC; tk = 0; ptk = 1; ptgt = 32'h40;
        cycle(); check("t6_rec_wrap", pc, 32'h0000_0000);
        idle(); repeat (2) cycle();

        // counter saturation: many mispredicts, then many correctly predicted branches
        for (int i = 0; i < 20; i++) begin
            mispredict(32'h100, 32'h200);
            cycle(); idle(); cycle(); cycle();
        end
        br = 1; tk = 0; ptk = 0;
        for (int i = 0; i < 65540; i++) cycle();
        check("t6_bc_sat", {16'b0, bc}, 32'h0000_FFFF);
        idle();
        mispredict(32'h300, 32'h400);
        cycle(); check("t6_bc_hold", {16'b0, bc}, 32'h0000_FFFF);
        check("t6_mc_sat_s", {28'b0, mc_s}, 32'd15);
        idle(); repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
